// File: rtl/squareroot_fp_digit.sv
// IEEE-754 square root, generic exponent/mantissa widths.
// Restoring digit-by-digit significand recurrence, one root bit per cycle, truncating.
module squareroot_fp_digit #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    output logic                   rdy,
    output logic                   busy,
    output logic [EXP_W+MAN_W:0]   sqrt,
    output logic                   invalid,
    output logic                   inexact,
    output logic [2:0]             state
);

    localparam int unsigned W      = EXP_W + MAN_W + 1;
    localparam int unsigned RAD_W  = 2 * MAN_W + 2;
    localparam int unsigned ROOT_W = MAN_W + 1;
    localparam int unsigned REM_W  = MAN_W + 3;
    localparam int unsigned TMP_W  = MAN_W + 5;
    localparam int unsigned CNT_W  = $clog2(MAN_W + 2);
    localparam int unsigned BIAS   = (1 << (EXP_W - 1)) - 1;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0] PINF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_DONE = 3'd3
    } state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        a_q;
    logic [RAD_W-1:0]    rad_q;
    logic [ROOT_W-1:0]   root_q;
    logic [REM_W-1:0]    rem_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [EXP_W-1:0]    exp_q;

    // operand classification and recurrence setup
    logic                s_c, e_zero_c, e_ones_c, m_nz_c;
    logic [EXP_W-1:0]    e_c;
    logic [ROOT_W-1:0]   m_int_c;
    logic signed [EXP_W:0] u_c, exp_s_c;
    logic [EXP_W-1:0]    exp_new_c;
    logic [RAD_W-1:0]    rad_new_c;

    always_comb begin
        s_c       = a_q[W-1];
        e_c       = a_q[W-2:MAN_W];
        m_int_c   = {1'b1, a_q[MAN_W-1:0]};
        e_zero_c  = (e_c == '0);
        e_ones_c  = &e_c;
        m_nz_c    = |a_q[MAN_W-1:0];
        u_c       = $signed({1'b0, e_c}) - $signed((EXP_W+1)'(BIAS));
        exp_s_c   = (u_c >>> 1) + $signed((EXP_W+1)'(BIAS));
        exp_new_c = EXP_W'(exp_s_c);
        rad_new_c = u_c[0] ? (RAD_W'(m_int_c) << (MAN_W + 1))
                           : (RAD_W'(m_int_c) << MAN_W);
    end

    // one restoring step: bring down two radicand bits, trial-subtract 4*root+1
    logic [TMP_W-1:0]    r_p_c, t_c, diff_c;
    logic                ge_c;
    logic [REM_W-1:0]    rem_step_c;
    logic [ROOT_W-1:0]   root_step_c;

    always_comb begin
        r_p_c       = {rem_q, rad_q[RAD_W-1 -: 2]};
        t_c         = TMP_W'({root_q, 2'b01});
        ge_c        = (r_p_c >= t_c);
        diff_c      = r_p_c - t_c;
        rem_step_c  = ge_c ? REM_W'(diff_c) : REM_W'(r_p_c);
        root_step_c = {root_q[ROOT_W-2:0], ge_c};
    end

    // next state and result selection
    logic                fin_c;
    logic [W-1:0]        res_c;
    logic                inv_c, inx_c;

    always_comb begin
        state_d = state_q;
        fin_c   = 1'b0;
        res_c   = sqrt;
        inv_c   = invalid;
        inx_c   = inexact;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_DONE;
                fin_c   = 1'b1;
                inv_c   = 1'b0;
                inx_c   = 1'b0;
                if (e_zero_c) begin
                    res_c = {s_c, {(W-1){1'b0}}};
                end else if (e_ones_c && m_nz_c) begin
                    res_c = QNAN;
                end else if (e_ones_c && !s_c) begin
                    res_c = PINF;
                end else if (s_c) begin
                    res_c = QNAN;
                    inv_c = 1'b1;
                end else begin
                    state_d = S_ITER;
                    fin_c   = 1'b0;
                end
            end
            S_ITER: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    fin_c   = 1'b1;
                    res_c   = {1'b0, exp_q, root_step_c[MAN_W-1:0]};
                    inv_c   = 1'b0;
                    inx_c   = (rem_step_c != '0);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            rad_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            rdy     <= 1'b0;
            busy    <= 1'b0;
            sqrt    <= '0;
            invalid <= 1'b0;
            inexact <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) a_q <= a;
            if (state_q == S_LOAD) begin
                rad_q  <= rad_new_c;
                root_q <= '0;
                rem_q  <= '0;
                cnt_q  <= CNT_W'(MAN_W + 1);
                exp_q  <= exp_new_c;
            end
            if (state_q == S_ITER) begin
                rad_q  <= rad_q << 2;
                root_q <= root_step_c;
                rem_q  <= rem_step_c;
                cnt_q  <= cnt_q - CNT_W'(1);
            end
            rdy  <= fin_c;
            busy <= (state_d != S_IDLE);
            if (fin_c) begin
                sqrt    <= res_c;
                invalid <= inv_c;
                inexact <= inx_c;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_squareroot_fp_digit.sv
// Scoreboard bench for squareroot_fp_digit: f32 and f16 instances, directed vectors.
module tb_squareroot_fp_digit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start32, start16;
    logic [31:0] a32, sqrt32;
    logic [15:0] a16, sqrt16;
    logic        rdy32, busy32, inv32, inx32;
    logic        rdy16, busy16, inv16, inx16;
    logic [2:0]  state32, state16;

    squareroot_fp_digit #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .rdy(rdy32), .busy(busy32),
        .sqrt(sqrt32), .invalid(inv32), .inexact(inx32), .state(state32));

    squareroot_fp_digit #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .rdy(rdy16), .busy(busy16),
        .sqrt(sqrt16), .invalid(inv16), .inexact(inx16), .state(state16));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] res;
        logic        inv;
        logic        inx;
        int          st;
        int          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // latency counts edges from the accepting edge through the DONE-entry edge, both inclusive
    task automatic issue32(input bit push, input logic [31:0] op, input logic [31:0] res,
                           input logic inv, input logic inx, input int lat);
        exp_t e;
        @(negedge clk);
        a32     = op;
        start32 = 1'b1;
        if (push) begin
            e = '{res, inv, inx, cyc + 1, lat};
            q32.push_back(e);
        end
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] op, input logic [15:0] res,
                           input logic inv, input logic inx, input int lat);
        exp_t e;
        @(negedge clk);
        a16     = op;
        start16 = 1'b1;
        e = '{{16'h0, res}, inv, inx, cyc + 1, lat};
        q16.push_back(e);
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic wait32();
        int n = 0;
        while ((q32.size() != 0 || busy32) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait32_timeout", 64'(n >= 200), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic wait16();
        int n = 0;
        while ((q16.size() != 0 || busy16) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait16_timeout", 64'(n >= 200), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    // f32 monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rdy32 === 1'b1) begin
                chk("rdy32_expected", 64'(q32.size() != 0), 64'(1));
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    chk("sqrt32",    64'(sqrt32), 64'(e.res));
                    chk("invalid32", 64'(inv32),  64'(e.inv));
                    chk("inexact32", 64'(inx32),  64'(e.inx));
                    chk("latency32", 64'(cyc - e.st + 1), 64'(e.lat));
                    @(negedge clk);
                    chk("rdy32_pulse", 64'(rdy32),  64'(0));
                    chk("busy32_fall", 64'(busy32), 64'(0));
                end
            end
        end
    end

    // f16 monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rdy16 === 1'b1) begin
                chk("rdy16_expected", 64'(q16.size() != 0), 64'(1));
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    chk("sqrt16",    64'(sqrt16), 64'(e.res[15:0]));
                    chk("invalid16", 64'(inv16),  64'(e.inv));
                    chk("inexact16", 64'(inx16),  64'(e.inx));
                    chk("latency16", 64'(cyc - e.st + 1), 64'(e.lat));
                    @(negedge clk);
                    chk("rdy16_pulse", 64'(rdy16), 64'(0));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] b2b_op  [3];
    logic [31:0] b2b_res [3];

    initial begin
        exp_t e;
        rst     = 1'b1;
        start32 = 1'b0;
        start16 = 1'b0;
        a32     = '0;
        a16     = '0;
        repeat (3) @(negedge clk);
        chk("reset_state32",   64'(state32), 64'(0));
        chk("reset_busy32",    64'(busy32),  64'(0));
        chk("reset_rdy32",     64'(rdy32),   64'(0));
        chk("reset_sqrt32",    64'(sqrt32),  64'(0));
        chk("reset_invalid32", 64'(inv32),   64'(0));
        chk("reset_inexact32", 64'(inx32),   64'(0));
        chk("reset_sqrt16",    64'(sqrt16),  64'(0));
        rst = 1'b0;
        @(negedge clk);

        // normal operands: rounding, exact results, even and odd exponents
        issue32(1, 32'h40000000, 32'h3FB504F3, 1'b0, 1'b1, 26); wait32();
        issue32(1, 32'h40400000, 32'h3FDDB3D7, 1'b0, 1'b1, 26); wait32();
        issue32(1, 32'h40800000, 32'h40000000, 1'b0, 1'b0, 26); wait32();
        issue32(1, 32'h3E800000, 32'h3F000000, 1'b0, 1'b0, 26); wait32();
        issue32(1, 32'h41100000, 32'h40400000, 1'b0, 1'b0, 26); wait32();

        // special values
        issue32(1, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 2); wait32();
        issue32(1, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 2); wait32();
        issue32(1, 32'h7F800000, 32'h7F800000, 1'b0, 1'b0, 2); wait32();
        issue32(1, 32'h7F800001, 32'h7FC00000, 1'b0, 1'b0, 2); wait32();
        issue32(1, 32'hBF800000, 32'h7FC00000, 1'b1, 1'b0, 2); wait32();
        issue32(1, 32'hFF800000, 32'h7FC00000, 1'b1, 1'b0, 2); wait32();

        // start while busy is dropped
        issue32(1, 32'h40000000, 32'h3FB504F3, 1'b0, 1'b1, 26);
        repeat (5) @(negedge clk);
        issue32(0, 32'h40800000, 32'h0, 1'b0, 1'b0, 0);
        wait32();

        // start held high: one acceptance every 27 cycles
        b2b_op[0] = 32'h40800000; b2b_res[0] = 32'h40000000;
        b2b_op[1] = 32'h41100000; b2b_res[1] = 32'h40400000;
        b2b_op[2] = 32'h3E800000; b2b_res[2] = 32'h3F000000;
        for (int j = 0; j < 81; j++) begin
            @(negedge clk);
            start32 = 1'b1;
            if (j % 27 == 0) begin
                a32 = b2b_op[j / 27];
                e = '{b2b_res[j / 27], 1'b0, 1'b0, cyc + 1, 26};
                q32.push_back(e);
            end else begin
                a32 = 32'h3F800000;
            end
        end
        @(negedge clk);
        start32 = 1'b0;
        wait32();

        // reset during ITER aborts without rdy
        issue32(0, 32'h40000000, 32'h0, 1'b0, 1'b0, 0);
        repeat (10) @(negedge clk);
        chk("iter_state32", 64'(state32), 64'(2));
        chk("iter_busy32",  64'(busy32),  64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_state32",   64'(state32), 64'(0));
        chk("abort_busy32",    64'(busy32),  64'(0));
        chk("abort_rdy32",     64'(rdy32),   64'(0));
        chk("abort_sqrt32",    64'(sqrt32),  64'(0));
        chk("abort_invalid32", 64'(inv32),   64'(0));
        chk("abort_inexact32", 64'(inx32),   64'(0));
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue32(1, 32'h40800000, 32'h40000000, 1'b0, 1'b0, 26); wait32();

        // f16 lane
        issue16(16'h4000, 16'h3DA8, 1'b0, 1'b1, 13); wait16();
        issue16(16'h4400, 16'h4000, 1'b0, 1'b0, 13); wait16();
        issue16(16'hFC00, 16'h7E00, 1'b1, 1'b0, 2);  wait16();

        chk("sb32_drained", 64'(q32.size()), 64'(0));
        chk("sb16_drained", 64'(q16.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
